// File: rtl/iter_mul_unit.sv
// iter_mul_unit: multi-cycle shift-add multiplier retiring STEP multiplier bits per cycle,
// covering MUL/MULH/MULHSU/MULHU by sign-magnitude correction. Option: MULT_ZERO_BYPASS_EN.
module iter_mul_unit #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned K      = WIDTH / STEP;
  localparam int unsigned CW     = $clog2(K + 1);
  localparam logic [1:0]  OP_MUL = 2'b00;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   bmag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   result_q;

  logic               a_neg, b_neg, accept, zero_op;
  logic [WIDTH-1:0]   amag, bmag;
  logic [WIDTH+STEP-1:0] pp, psum;
  logic [2*WIDTH-1:0] acc_step, mag_fix;

  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign product   = product_q;
  assign result    = result_q;

  // a is signed for every op but MULHU; b only for MUL/MULH
  always_comb begin
    a_neg = (op != 2'b11) && a[WIDTH-1];
    b_neg = !op[1] && b[WIDTH-1];
    amag  = a_neg ? ('0 - a) : a;
    bmag  = b_neg ? ('0 - b) : b;
  end

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (amag == '0) || (bmag == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Upper half accumulates |b| * digit with STEP bits of headroom, then the whole
  // accumulator shifts right by STEP, consuming the low multiplier digit.
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (acc_q[i]) pp = pp + ((WIDTH+STEP)'(bmag_q) << i);
    end
    psum     = (WIDTH+STEP)'(acc_q[2*WIDTH-1:WIDTH]) + pp;
    acc_step = (2*WIDTH)'({psum, acc_q[WIDTH-1:0]} >> STEP);
    mag_fix  = neg_q ? ('0 - acc_q) : acc_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_op ? DONE : BUSY;
      BUSY:    if (cnt_q == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      bmag_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= op;
            neg_q  <= a_neg ^ b_neg;
            bmag_q <= bmag;
            acc_q  <= {{WIDTH{1'b0}}, amag};
            cnt_q  <= CW'(K);
            if (zero_op) begin
              product_q <= '0;
              result_q  <= '0;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          if (!flush) begin
            product_q <= mag_fix;
            result_q  <= (op_q == OP_MUL) ? mag_fix[WIDTH-1:0] : mag_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
